hazard_fwd_unit: RTL and testbench

- Hazard detection and forwarding stage for the 5-stage RV32I pipeline. It sits directly downstream of the ID-stage instruction decoder.
- It consumes the decoder's rs1use/rs2use/hazard_optype/Branch outputs together with the ID register indices.
- It tracks the destination and class of the instructions in EX and MEM in internal tag registers.
- It drives pipeline enables/flushes and the ID-stage operand forwarding muxes. Branches resolve in ID, so forwarding targets ID.

---
 rtl/hazard_fwd_unit_if.sv | 32 +++
 rtl/hazard_fwd_unit.sv | 92 +++++++++
 tb/tb_hazard_fwd_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage hazard/forwarding bundle: decoder-side operand info in, pipeline
// control and forwarding selects out.
interface hazard_fwd_unit_if #(
  parameter int unsigned REG_W = 5
);
  logic [REG_W-1:0] rs1_ID;
  logic [REG_W-1:0] rs2_ID;
  logic [REG_W-1:0] rd_ID;
  logic             rs1use_ID;
  logic             rs2use_ID;
  logic [1:0]       hazard_optype_ID;
  logic             Branch_ID;
  logic             PC_EN_IF;
  logic             reg_FD_EN;
  logic             reg_FD_flush;
  logic             reg_DE_flush;
  logic [1:0]       forward_ctrl_A;
  logic [1:0]       forward_ctrl_B;
  logic             forward_ctrl_ls;

  modport master (
    output rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID, hazard_optype_ID, Branch_ID,
    input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );

  modport slave (
    input  rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID, hazard_optype_ID, Branch_ID,
    output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and ID-stage forwarding for a 5-stage RV32I pipeline with
// branches resolved in ID. Tracks EX/MEM producer tags internally.
module hazard_fwd_unit #(
  parameter int unsigned REG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_fwd_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_ALU   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } optype_e;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    optype_e          op;
    logic             ls;
  } tag_t;

  tag_t    ex_tag;
  tag_t    mem_tag;
  logic    fwd_ls_q;
  optype_e id_op;

  logic ex_prod, mem_prod;
  logic m1_ex, m2_ex, m1_mem, m2_mem;
  logic load_use, store_data_fwd, stall;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic is_producer(input tag_t t);
    return t.v && (t.rd != '0) && ((t.op == OP_ALU) || (t.op == OP_LOAD));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem,
                                         input optype_e ex_op, input optype_e mem_op);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_ex && ex_op == OP_ALU)          sel = 2'b01;
    else if (m_mem && mem_op == OP_ALU)   sel = 2'b10;
    else if (m_mem && mem_op == OP_LOAD)  sel = 2'b11;
    return sel;
  endfunction

  assign id_op = optype_e'(bus.hazard_optype_ID);

  always_comb begin
    ex_prod  = is_producer(ex_tag);
    mem_prod = is_producer(mem_tag);
    m1_ex    = bus.rs1use_ID && (bus.rs1_ID == ex_tag.rd)  && ex_prod;
    m2_ex    = bus.rs2use_ID && (bus.rs2_ID == ex_tag.rd)  && ex_prod;
    m1_mem   = bus.rs1use_ID && (bus.rs1_ID == mem_tag.rd) && mem_prod;
    m2_mem   = bus.rs2use_ID && (bus.rs2_ID == mem_tag.rd) && mem_prod;

    fwd_a = fwd_sel(m1_ex, m1_mem, ex_tag.op, mem_tag.op);
    fwd_b = fwd_sel(m2_ex, m2_mem, ex_tag.op, mem_tag.op);

    // A store whose only dependency on the EX load is its write data can
    // proceed; the data is patched in MEM from the WB load result.
    store_data_fwd = (ex_tag.op == OP_LOAD) && (id_op == OP_STORE) && m2_ex && !m1_ex;
    load_use       = (ex_tag.op == OP_LOAD) && (m1_ex || m2_ex);
    stall          = load_use && !store_data_fwd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_tag   <= '{v: 1'b0, rd: '0, op: OP_NONE, ls: 1'b0};
      mem_tag  <= '{v: 1'b0, rd: '0, op: OP_NONE, ls: 1'b0};
      fwd_ls_q <= 1'b0;
    end else begin
      mem_tag  <= ex_tag;
      fwd_ls_q <= ex_tag.ls;
      if (stall)
        ex_tag <= '{v: 1'b0, rd: '0, op: OP_NONE, ls: 1'b0};
      else
        ex_tag <= '{v: 1'b1, rd: bus.rd_ID, op: id_op, ls: store_data_fwd};
    end
  end

  assign bus.PC_EN_IF        = !stall;
  assign bus.reg_FD_EN       = !stall;
  assign bus.reg_DE_flush    = stall;
  assign bus.reg_FD_flush    = bus.Branch_ID && !stall;
  assign bus.forward_ctrl_A  = fwd_a;
  assign bus.forward_ctrl_B  = fwd_b;
  assign bus.forward_ctrl_ls = fwd_ls_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline scenarios plus random traffic,
// checked every cycle against an instruction-history model.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REG_W(5)) bus ();

  hazard_fwd_unit #(.REG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit check_en = 1'b0;

  // Older instructions: hist[0] is one slot ahead of ID, hist[1] two slots.
  typedef struct {
    bit v;
    int rd;
    int typ;
    bit ls;
  } instr_t;
  instr_t hist[2];
  bit     ls_q;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(input instr_t i, input int r);
    return i.v && i.rd != 0 && i.rd == r && (i.typ == 1 || i.typ == 2);
  endfunction

  function automatic bit dep(input int idx, input bit use_r, input int r);
    return use_r && writes(hist[idx], r);
  endfunction

  function automatic logic [1:0] m_fwd(input bit use_r, input int r);
    if (dep(0, use_r, r) && hist[0].typ == 1) return 2'b01;
    if (dep(1, use_r, r)) return (hist[1].typ == 1) ? 2'b10 : 2'b11;
    return 2'b00;
  endfunction

  function automatic bit m_store_ok();
    return hist[0].typ == 2 && bus.hazard_optype_ID == 2'd3 &&
           dep(0, bus.rs2use_ID, int'(bus.rs2_ID)) && !dep(0, bus.rs1use_ID, int'(bus.rs1_ID));
  endfunction

  function automatic bit m_stall();
    bit d;
    d = dep(0, bus.rs1use_ID, int'(bus.rs1_ID)) || dep(0, bus.rs2use_ID, int'(bus.rs2_ID));
    return hist[0].typ == 2 && d && !m_store_ok();
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      hist[0] = '{0, 0, 0, 0};
      hist[1] = '{0, 0, 0, 0};
      ls_q = 0;
    end else begin
      instr_t nw;
      if (m_stall()) nw = '{0, 0, 0, 0};
      else nw = '{1, int'(bus.rd_ID), int'(bus.hazard_optype_ID), m_store_ok()};
      ls_q = hist[0].ls;
      hist[1] = hist[0];
      hist[0] = nw;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      bit s;
      s = m_stall();
      chk("pc_en",    bus.PC_EN_IF,        !s);
      chk("fd_en",    bus.reg_FD_EN,       !s);
      chk("de_flush", bus.reg_DE_flush,    s);
      chk("fd_flush", bus.reg_FD_flush,    bus.Branch_ID && !s);
      chk("fwd_A",    bus.forward_ctrl_A,  m_fwd(bus.rs1use_ID, int'(bus.rs1_ID)));
      chk("fwd_B",    bus.forward_ctrl_B,  m_fwd(bus.rs2use_ID, int'(bus.rs2_ID)));
      chk("fwd_ls",   bus.forward_ctrl_ls, ls_q);
    end
  end

  task automatic drive(input int rs1, input int rs2, input int rd, input bit u1,
                       input bit u2, input int typ, input bit br);
    bus.rs1_ID = 5'(rs1);
    bus.rs2_ID = 5'(rs2);
    bus.rd_ID = 5'(rd);
    bus.rs1use_ID = u1;
    bus.rs2use_ID = u2;
    bus.hazard_optype_ID = 2'(typ);
    bus.Branch_ID = br;
  endtask

  // Advance to the next cycle and present a new ID instruction.
  task automatic nxt(input int rs1, input int rs2, input int rd, input bit u1,
                     input bit u2, input int typ, input bit br);
    @(posedge clk);
    #1;
    drive(rs1, rs2, rd, u1, u2, typ, br);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    chk("rst_pc_en", bus.PC_EN_IF, 1'b1);
    chk("rst_fwd_A", bus.forward_ctrl_A, 2'b00);
    chk("rst_fwd_ls", bus.forward_ctrl_ls, 1'b0);
    rst_n = 1'b1;

    // ALU forwarding from EX then MEM
    nxt(0, 0, 5, 0, 0, 1, 0);
    nxt(5, 0, 9, 1, 0, 1, 0);
    chk("t1_fwdA_ex", bus.forward_ctrl_A, 2'b01);
    chk("t1_pc_en", bus.PC_EN_IF, 1'b1);
    nxt(0, 5, 10, 0, 1, 1, 0);
    chk("t1_fwdB_mem", bus.forward_ctrl_B, 2'b10);

    // load-use: one stall cycle, then load data forwarded
    nxt(0, 0, 6, 0, 0, 2, 0);
    nxt(6, 0, 11, 1, 0, 1, 0);
    chk("t2_pc_en", bus.PC_EN_IF, 1'b0);
    chk("t2_fd_en", bus.reg_FD_EN, 1'b0);
    chk("t2_de_flush", bus.reg_DE_flush, 1'b1);
    nxt(6, 0, 11, 1, 0, 1, 0);
    chk("t2_fwdA_ld", bus.forward_ctrl_A, 2'b11);
    chk("t2_pc_en2", bus.PC_EN_IF, 1'b1);

    // load then store of that data: no stall, ls flag when store reaches MEM
    nxt(0, 0, 7, 0, 0, 2, 0);
    nxt(2, 7, 0, 1, 1, 3, 0);
    chk("t3_no_stall", bus.PC_EN_IF, 1'b1);
    nxt(0, 0, 0, 0, 0, 0, 0);
    chk("t3_ls_early", bus.forward_ctrl_ls, 1'b0);
    nxt(0, 0, 0, 0, 0, 0, 0);
    chk("t3_ls", bus.forward_ctrl_ls, 1'b1);
    nxt(0, 0, 0, 0, 0, 0, 0);
    chk("t3_ls_end", bus.forward_ctrl_ls, 1'b0);

    // x0 never forwarded
    nxt(0, 0, 0, 0, 0, 1, 0);
    nxt(0, 0, 12, 1, 0, 1, 0);
    chk("t4_x0", bus.forward_ctrl_A, 2'b00);

    // EX priority over MEM
    nxt(0, 0, 8, 0, 0, 1, 0);
    nxt(0, 0, 8, 0, 0, 1, 0);
    nxt(8, 0, 13, 1, 0, 1, 0);
    chk("t5_ex_prio", bus.forward_ctrl_A, 2'b01);

    // branch without / with hazard, then reset during the stall
    nxt(0, 0, 0, 0, 0, 0, 0);
    nxt(0, 0, 0, 0, 0, 0, 1);
    chk("t6_br_flush", bus.reg_FD_flush, 1'b1);
    chk("t6_br_pc_en", bus.PC_EN_IF, 1'b1);
    nxt(0, 0, 6, 0, 0, 2, 0);
    nxt(6, 0, 14, 1, 0, 1, 1);
    chk("t6_stall_flush", bus.reg_FD_flush, 1'b0);
    chk("t6_stall_pc", bus.PC_EN_IF, 1'b0);
    rst_n = 1'b0;
    nxt(0, 0, 0, 0, 0, 0, 0);
    chk("t6_rst_pc_en", bus.PC_EN_IF, 1'b1);
    chk("t6_rst_de", bus.reg_DE_flush, 1'b0);
    rst_n = 1'b1;

    // random traffic over a small register set to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), $urandom_range(0, 3),
            ($urandom_range(0, 4) == 0));
    end
    @(posedge clk);
    #1;
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
